unary_add_seq_ctrl: RTL and testbench

Sequencer for the team's serial unary adder (ports A, B, en, read_or_write, dout, C).
- Takes two binary operand counts from a host and expands each into a thermometer bitstream on A/B.
- Drives the adder's read phase, then its write phase, and counts the ones on dout back into a binary result.
- Sits between a host register interface and a single unary adder instance, so the host never toggles en or read_or_write cycle by cycle.

---
 rtl/unary_add_seq_ctrl.sv | 154 +++++++++++++++
 tb/tb_unary_add_seq_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unary_add_seq_ctrl.sv
// Sequencer for a serial unary adder: expands two operand counts into thermometer streams,
// runs the adder's read then write phase, and counts dout ones. Option: UNARY_CTRL_EARLY_END_EN.
module unary_add_seq_ctrl #(
  parameter int IN_LEN  = 15,
  parameter int OUT_LEN = 20,
  parameter int CNT_W   = 5,
  parameter int RES_W   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] a_cnt,
  input  logic [CNT_W-1:0] b_cnt,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] result,
  output logic             ovf,
  output logic             add_A,
  output logic             add_B,
  output logic             add_en,
  output logic             add_rw,
  input  logic             add_dout,
  input  logic             add_C
);

  localparam int MAX_LEN = (IN_LEN > OUT_LEN) ? IN_LEN : OUT_LEN;
  localparam int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   a_lat_q, b_lat_q;
  logic [RES_W-1:0]   result_q;
  logic               busy_q, done_q, ovf_q, add_a_q, add_b_q, add_en_q, add_rw_q;

  logic [CNT_W-1:0]   a_sat_d, b_sat_d;
  logic [IDX_W-1:0]   idx_inc_d;
  logic [RES_W-1:0]   result_inc_d;
  logic               read_last_d, write_last_d, early_end_d;

  always_comb begin
    a_sat_d      = (32'(a_cnt) > 32'(IN_LEN)) ? CNT_W'(IN_LEN) : a_cnt;
    b_sat_d      = (32'(b_cnt) > 32'(IN_LEN)) ? CNT_W'(IN_LEN) : b_cnt;
    idx_inc_d    = idx_q + IDX_W'(1);
    result_inc_d = (add_dout && (result_q != '1)) ? result_q + RES_W'(1) : result_q;
    read_last_d  = (32'(idx_q) == 32'(IN_LEN - 1));
    write_last_d = (32'(idx_q) == 32'(OUT_LEN - 1));
`ifdef UNARY_CTRL_EARLY_END_EN
    // A zero after at least one counted one marks the end of the adder's thermometer output.
    early_end_d  = (result_q != '0) && !add_dout;
`else
    early_end_d  = 1'b0;
`endif
  end

  // Handshake: start is sampled only in IDLE (abort in the same cycle cancels it); busy covers
  // READ and WRITE; done is a single-cycle pulse, and result/ovf stay valid until the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      a_lat_q  <= '0;
      b_lat_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      add_a_q  <= 1'b0;
      add_b_q  <= 1'b0;
      add_en_q <= 1'b0;
      add_rw_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            a_lat_q  <= a_sat_d;
            b_lat_q  <= b_sat_d;
            result_q <= '0;
            ovf_q    <= 1'b0;
            idx_q    <= '0;
            busy_q   <= 1'b1;
            add_en_q <= 1'b1;
            add_rw_q <= 1'b0;
            add_a_q  <= (a_sat_d != '0);
            add_b_q  <= (b_sat_d != '0);
            state_q  <= S_READ;
          end
        end
        S_READ: begin
          if (abort) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            add_en_q <= 1'b0;
            add_rw_q <= 1'b0;
            add_a_q  <= 1'b0;
            add_b_q  <= 1'b0;
          end else begin
            ovf_q <= ovf_q | add_C;
            if (read_last_d) begin
              state_q  <= S_WRITE;
              idx_q    <= '0;
              add_rw_q <= 1'b1;
              add_a_q  <= 1'b0;
              add_b_q  <= 1'b0;
            end else begin
              // Outputs are registered, so drive the stream bit for the next index.
              idx_q   <= idx_inc_d;
              add_a_q <= (32'(idx_inc_d) < 32'(a_lat_q));
              add_b_q <= (32'(idx_inc_d) < 32'(b_lat_q));
            end
          end
        end
        S_WRITE: begin
          if (abort) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            add_en_q <= 1'b0;
            add_rw_q <= 1'b0;
          end else begin
            ovf_q    <= ovf_q | add_C;
            result_q <= result_inc_d;
            if (write_last_d || early_end_d) begin
              state_q  <= S_DONE;
              idx_q    <= '0;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              add_en_q <= 1'b0;
              add_rw_q <= 1'b0;
            end else begin
              idx_q <= idx_inc_d;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign ovf    = ovf_q;
  assign add_A  = add_a_q;
  assign add_B  = add_b_q;
  assign add_en = add_en_q;
  assign add_rw = add_rw_q;

endmodule

// File: tb/tb_unary_add_seq_ctrl.sv
// Self-checking bench for unary_add_seq_ctrl: scripted and random operations against a cycle-level
// reference model of the operation timeline (streams, phases, result and overflow).
module tb_unary_add_seq_ctrl;
  localparam int IN_LEN  = 15;
  localparam int OUT_LEN = 20;
  localparam int CNT_W   = 5;
  localparam int RES_W   = 6;
  localparam int MAXC    = 63;
`ifdef UNARY_CTRL_EARLY_END_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, start, abort, add_dout, add_C;
  logic [CNT_W-1:0] a_cnt, b_cnt;
  logic busy, done, ovf, add_A, add_B, add_en, add_rw;
  logic [RES_W-1:0] result;

  unary_add_seq_ctrl #(.IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .CNT_W(CNT_W), .RES_W(RES_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .a_cnt(a_cnt), .b_cnt(b_cnt),
    .busy(busy), .done(done), .result(result), .ovf(ovf), .add_A(add_A), .add_B(add_B),
    .add_en(add_en), .add_rw(add_rw), .add_dout(add_dout), .add_C(add_C)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-cycle adder responses for the current operation (cycle 1 = first READ cycle).
  logic dout_tbl[0:MAXC];
  logic c_tbl[0:MAXC];
  // Observations per cycle: {busy, done, add_en, add_rw, add_A, add_B}.
  logic [5:0]       obs_ctl[0:MAXC];
  logic [RES_W-1:0] obs_res[0:MAXC];
  logic             obs_ovf[0:MAXC];
  int obs_n;

  int   m_a, m_b, m_done_cyc, m_abort_cyc, m_res;
  logic m_ovf;

  function automatic int sat_op(input int x);
    return (x > IN_LEN) ? IN_LEN : x;
  endfunction

  // An ideal unary adder: emits sum ones then zeros, carry while the sum exceeds the write window.
  task automatic fill_adder(input int a, input int b);
    int sum;
    sum = sat_op(a) + sat_op(b);
    for (int k = 0; k <= MAXC; k++) begin
      dout_tbl[k] = (k > IN_LEN) && (k <= IN_LEN + OUT_LEN) && ((k - IN_LEN - 1) < sum);
      c_tbl[k]    = (k > IN_LEN) && (k <= IN_LEN + OUT_LEN) && (sum > OUT_LEN);
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k <= MAXC; k++) begin
      dout_tbl[k] = 1'($urandom_range(0, 1));
      c_tbl[k]    = ($urandom_range(0, 15) == 0);
    end
  endtask

  // Timeline model: abort_cyc = cycle in which abort is held (0 = none).
  task automatic compute_model(input int a, input int b, input int abort_cyc);
    m_a = sat_op(a);
    m_b = sat_op(b);
    m_abort_cyc = abort_cyc;
    m_res = 0;
    m_ovf = 1'b0;
    m_done_cyc = 0;
    for (int k = 1; k <= IN_LEN + OUT_LEN; k++) begin
      if (abort_cyc != 0 && k >= abort_cyc) break;
      m_ovf = m_ovf | c_tbl[k];
      if (k > IN_LEN) begin
        if (EARLY && m_res > 0 && !dout_tbl[k]) begin
          m_done_cyc = k + 1;
          break;
        end
        if (dout_tbl[k] && m_res < (1 << RES_W) - 1) m_res++;
      end
      if (k == IN_LEN + OUT_LEN) m_done_cyc = k + 1;
    end
  endtask

  function automatic logic [5:0] exp_ctl(input int k);
    int   last_act;
    logic act, rd;
    last_act = (m_abort_cyc != 0) ? m_abort_cyc : m_done_cyc - 1;
    act = (k >= 1) && (k <= last_act);
    rd  = act && (k <= IN_LEN);
    return {act, (m_abort_cyc == 0) && (k == m_done_cyc), act, act && (k > IN_LEN),
            rd && (k <= m_a), rd && (k <= m_b)};
  endfunction

  // Drives one start and plays the response table; returns at the negedge of the IDLE cycle
  // after done, or after a fixed budget if no done appears.
  task automatic run_op(input int a, input int b, input int abort_cyc, input int rst_cyc,
                        input bit repulse);
    for (int k = 0; k <= MAXC; k++) begin
      obs_ctl[k] = 'x;
      obs_res[k] = 'x;
      obs_ovf[k] = 1'bx;
    end
    a_cnt = CNT_W'(a);
    b_cnt = CNT_W'(b);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    obs_n = 0;
    for (int k = 1; k <= 45; k++) begin
      obs_ctl[k] = {busy, done, add_en, add_rw, add_A, add_B};
      obs_res[k] = result;
      obs_ovf[k] = ovf;
      obs_n = k;
      if (k > 1 && obs_ctl[k-1][4] === 1'b1) break;
      add_dout = dout_tbl[k];
      add_C    = c_tbl[k];
      abort    = (k == abort_cyc);
      start    = repulse && (k == 5 || k == 20);
      if (start) begin
        a_cnt = CNT_W'($urandom_range(0, 31));
        b_cnt = CNT_W'($urandom_range(0, 31));
      end
      if (rst_cyc != 0 && k == rst_cyc) rst_n = 1'b0;
      if (rst_cyc != 0 && k == rst_cyc + 2) rst_n = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
    add_dout = 1'b0;
    add_C = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; add_dout = 1'b0; add_C = 1'b0;
    a_cnt = '0; b_cnt = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({busy, done, add_en, add_rw, add_A, add_B, ovf, result} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold outputs got %b exp 0", {busy, done, add_en, add_rw, add_A, add_B, ovf, result});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({busy, done, add_en, add_rw, add_A, add_B, ovf, result} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle outputs got %b exp 0", {busy, done, add_en, add_rw, add_A, add_B, ovf, result});
    end
  endtask

  task automatic test_operands();
    int ta[4] = '{3, 0, 31, 15};
    int tb[4] = '{2, 0, 31, 9};
    for (int t = 0; t < 4; t++) begin
      fill_adder(ta[t], tb[t]);
      compute_model(ta[t], tb[t], 0);
      run_op(ta[t], tb[t], 0, 0, 1'b0);
      for (int k = 1; k <= obs_n; k++) begin
        n_tests++;
        if (obs_ctl[k] !== exp_ctl(k)) begin
          n_fail++;
          $display("FAIL operands[%0d] ctl cyc %0d got %b exp %b", t, k, obs_ctl[k], exp_ctl(k));
        end
      end
      n_tests++;
      if (obs_res[m_done_cyc] !== RES_W'(m_res) || obs_ovf[m_done_cyc] !== m_ovf) begin
        n_fail++;
        $display("FAIL operands[%0d] result/ovf got %0d/%b exp %0d/%b", t,
                 obs_res[m_done_cyc], obs_ovf[m_done_cyc], m_res, m_ovf);
      end
      n_tests++;
      if (result !== RES_W'(m_res) || ovf !== m_ovf) begin
        n_fail++;
        $display("FAIL operands[%0d] held got %0d/%b exp %0d/%b", t, result, ovf, m_res, m_ovf);
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_random();
    int a, b;
    for (int t = 0; t < 8; t++) begin
      a = $urandom_range(0, 31);
      b = $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) fill_random();
      else fill_adder(a, b);
      compute_model(a, b, 0);
      run_op(a, b, 0, 0, 1'b0);
      for (int k = 1; k <= obs_n; k++) begin
        n_tests++;
        if (obs_ctl[k] !== exp_ctl(k)) begin
          n_fail++;
          $display("FAIL random[%0d] ctl cyc %0d got %b exp %b (a=%0d b=%0d)", t, k, obs_ctl[k], exp_ctl(k), a, b);
        end
      end
      n_tests++;
      if (obs_res[1] !== '0 || obs_ovf[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL random[%0d] clear_at_start got %0d/%b exp 0/0", t, obs_res[1], obs_ovf[1]);
      end
      n_tests++;
      if (obs_res[m_done_cyc] !== RES_W'(m_res) || obs_ovf[m_done_cyc] !== m_ovf) begin
        n_fail++;
        $display("FAIL random[%0d] result/ovf got %0d/%b exp %0d/%b", t,
                 obs_res[m_done_cyc], obs_ovf[m_done_cyc], m_res, m_ovf);
      end
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int a, b;
    for (int t = 0; t < 3; t++) begin
      a = $urandom_range(0, 20);
      b = $urandom_range(0, 20);
      fill_random();
      compute_model(a, b, 0);
      run_op(a, b, 0, 0, 1'b0);
      for (int k = 1; k <= obs_n; k++) begin
        n_tests++;
        if (obs_ctl[k] !== exp_ctl(k)) begin
          n_fail++;
          $display("FAIL back_to_back[%0d] ctl cyc %0d got %b exp %b", t, k, obs_ctl[k], exp_ctl(k));
        end
      end
      n_tests++;
      if (obs_res[m_done_cyc] !== RES_W'(m_res) || obs_ovf[m_done_cyc] !== m_ovf) begin
        n_fail++;
        $display("FAIL back_to_back[%0d] result/ovf got %0d/%b exp %0d/%b", t,
                 obs_res[m_done_cyc], obs_ovf[m_done_cyc], m_res, m_ovf);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    fill_adder(3, 2);
    compute_model(3, 2, 0);
    run_op(3, 2, 0, 0, 1'b1);
    for (int k = 1; k <= obs_n; k++) begin
      n_tests++;
      if (obs_ctl[k] !== exp_ctl(k)) begin
        n_fail++;
        $display("FAIL start_while_busy ctl cyc %0d got %b exp %b", k, obs_ctl[k], exp_ctl(k));
      end
    end
    n_tests++;
    if (obs_res[m_done_cyc] !== RES_W'(m_res)) begin
      n_fail++;
      $display("FAIL start_while_busy result got %0d exp %0d", obs_res[m_done_cyc], m_res);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    fill_adder(5, 5);
    compute_model(5, 5, 10);
    run_op(5, 5, 10, 0, 1'b0);
    for (int k = 1; k <= obs_n; k++) begin
      n_tests++;
      if (obs_ctl[k] !== exp_ctl(k)) begin
        n_fail++;
        $display("FAIL abort_read ctl cyc %0d got %b exp %b", k, obs_ctl[k], exp_ctl(k));
      end
    end
    fill_adder(3, 2);
    compute_model(3, 2, 25);
    run_op(3, 2, 25, 0, 1'b0);
    for (int k = 1; k <= obs_n; k++) begin
      n_tests++;
      if (obs_ctl[k] !== exp_ctl(k)) begin
        n_fail++;
        $display("FAIL abort_write ctl cyc %0d got %b exp %b", k, obs_ctl[k], exp_ctl(k));
      end
    end
    n_tests++;
    if (obs_res[obs_n] !== RES_W'(m_res) || obs_ovf[obs_n] !== m_ovf) begin
      n_fail++;
      $display("FAIL abort_write partial got %0d/%b exp %0d/%b", obs_res[obs_n], obs_ovf[obs_n], m_res, m_ovf);
    end
    // start and abort together in IDLE: must not be accepted, so the partial result survives.
    a_cnt = CNT_W'(3);
    b_cnt = CNT_W'(3);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || add_en !== 1'b0 || result !== RES_W'(m_res)) begin
      n_fail++;
      $display("FAIL start_with_abort busy/en/result got %b/%b/%0d exp 0/0/%0d", busy, add_en, result, m_res);
    end
    fill_adder(1, 1);
    compute_model(1, 1, 0);
    run_op(1, 1, 0, 0, 1'b0);
    n_tests++;
    if (obs_res[m_done_cyc] !== RES_W'(2) || obs_ctl[m_done_cyc] !== 6'b010000) begin
      n_fail++;
      $display("FAIL after_abort result/ctl got %0d/%b exp 2/010000", obs_res[m_done_cyc], obs_ctl[m_done_cyc]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    fill_adder(7, 4);
    compute_model(7, 4, 18);
    run_op(7, 4, 0, 18, 1'b0);
    for (int k = 1; k <= obs_n; k++) begin
      n_tests++;
      if (k <= 18) begin
        if (obs_ctl[k] !== exp_ctl(k)) begin
          n_fail++;
          $display("FAIL reset_mid ctl cyc %0d got %b exp %b", k, obs_ctl[k], exp_ctl(k));
        end
      end else if ({obs_ctl[k], obs_ovf[k], obs_res[k]} !== '0) begin
        n_fail++;
        $display("FAIL reset_mid cleared cyc %0d got %b/%b/%0d exp all 0", k, obs_ctl[k], obs_ovf[k], obs_res[k]);
      end
    end
    fill_adder(4, 6);
    compute_model(4, 6, 0);
    run_op(4, 6, 0, 0, 1'b0);
    for (int k = 1; k <= obs_n; k++) begin
      n_tests++;
      if (obs_ctl[k] !== exp_ctl(k)) begin
        n_fail++;
        $display("FAIL reset_mid_restart ctl cyc %0d got %b exp %b", k, obs_ctl[k], exp_ctl(k));
      end
    end
    n_tests++;
    if (obs_res[m_done_cyc] !== RES_W'(m_res)) begin
      n_fail++;
      $display("FAIL reset_mid_restart result got %0d exp %0d", obs_res[m_done_cyc], m_res);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_operands();
    test_random();
    test_back_to_back();
    test_start_while_busy();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
